// File: rtl/cnn_res_reader_if.sv
// Result-bus and CPU read-port bundle for cnn_res_reader.
// The producer/CPU side uses master; the reader block uses slave.
interface cnn_res_reader_if #(
  parameter int unsigned DW = 8
) ();
  logic [DW-1:0] Res_reg;
  logic          res_valid;
  logic          res_last;
  logic          res_ready;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          frame_done;
  logic          frame_ack;
  logic [DW-1:0] max_val;
  logic [7:0]    max_idx;
  logic [1:0]    err;

  modport master (
    output Res_reg, res_valid, res_last, rd_en, frame_ack,
    input  res_ready, rd_data, rd_valid, count, empty, full,
           frame_done, max_val, max_idx, err
  );

  modport slave (
    input  Res_reg, res_valid, res_last, rd_en, frame_ack,
    output res_ready, rd_data, rd_valid, count, empty, full,
           frame_done, max_val, max_idx, err
  );
endinterface

// File: rtl/cnn_res_reader.sv
// Buffers CNN result bytes in a small FIFO for the CPU and tracks the
// per-frame maximum and its index; sticky error flags for misuse.
module cnn_res_reader #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input logic              clock,
  input logic              reset,
  cnn_res_reader_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 5;
  localparam int unsigned IW = 8;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;
  logic [DW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_frame_done;
  logic [DW-1:0]   r_max_val;
  logic [IW-1:0]   r_max_idx;
  logic [IW-1:0]   r_sample_cnt;
  logic [1:0]      r_err;

  logic            w_ready;
  logic            w_accept;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;

  // res_ready is intentionally combinational from registered state only
  assign w_ready     = !r_full && (r_state != DONE);
  assign w_accept    = bus.res_valid && w_ready;
  assign w_pop       = bus.rd_en && !r_empty;
  assign w_count_nxt = r_count + CW'(w_accept) - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = bus.res_last ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (w_accept && bus.res_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.frame_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge clock) begin
    if (reset && w_accept) begin
      r_mem[r_wr_ptr] <= bus.Res_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_max_val    <= '0;
      r_max_idx    <= '0;
      r_sample_cnt <= '0;
      r_err        <= '0;
    end else begin
      r_rd_valid   <= w_pop;
      r_count      <= w_count_nxt;
      r_empty      <= (w_count_nxt == '0);
      r_full       <= (w_count_nxt == CW'(DEPTH));
      r_frame_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (bus.rd_en && r_empty) begin
        r_err[0] <= 1'b1;
      end
      if (bus.res_valid && !w_ready) begin
        r_err[1] <= 1'b1;
      end
      // First sample of a frame seeds the max; later ones replace it only if strictly larger
      if (w_accept) begin
        if (r_state == IDLE) begin
          r_max_val    <= bus.Res_reg;
          r_max_idx    <= '0;
          r_sample_cnt <= IW'(1);
        end else begin
          if (bus.Res_reg > r_max_val) begin
            r_max_val <= bus.Res_reg;
            r_max_idx <= r_sample_cnt;
          end
          if (r_sample_cnt != '1) begin
            r_sample_cnt <= r_sample_cnt + IW'(1);
          end
        end
      end
    end
  end

  assign bus.res_ready  = w_ready;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.count      = r_count;
  assign bus.empty      = r_empty;
  assign bus.full       = r_full;
  assign bus.frame_done = r_frame_done;
  assign bus.max_val    = r_max_val;
  assign bus.max_idx    = r_max_idx;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_cnn_res_reader.sv
// Scoreboard bench for cnn_res_reader: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cnn_res_reader;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  logic clock = 1'b0;
  logic reset;

  cnn_res_reader_if #(.DW(DW)) bus ();

  cnn_res_reader #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;

  rd_exp_t    sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc_n  = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  logic [7:0] m_frame[$];
  bit         m_collect = 0;
  bit         m_done    = 0;
  bit         m_live    = 0;
  bit         m_rd_valid;
  logic [7:0] m_rd_data;
  logic [7:0] m_max_val;
  logic [7:0] m_max_idx;
  logic [1:0] m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  function automatic void m_rescan();
    m_max_val = m_frame[0];
    m_max_idx = 8'd0;
    for (int i = 1; i < m_frame.size(); i++) begin
      if (m_frame[i] > m_max_val) begin
        m_max_val = m_frame[i];
        m_max_idx = (i > 255) ? 8'd255 : 8'(i);
      end
    end
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_frame.delete();
    m_collect  = 0;
    m_done     = 0;
    m_rd_valid = 0;
    m_rd_data  = '0;
    m_max_val  = '0;
    m_max_idx  = '0;
    m_err      = '0;
    m_live     = 1;
  endfunction

  task automatic check_state();
    chk("count",      32'(bus.count),      32'(m_fifo.size()));
    chk("empty",      32'(bus.empty),      32'(m_fifo.size() == 0));
    chk("full",       32'(bus.full),       32'(m_fifo.size() == DEPTH));
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    chk("max_val",    32'(bus.max_val),    32'(m_max_val));
    chk("max_idx",    32'(bus.max_idx),    32'(m_max_idx));
    chk("err",        32'(bus.err),        32'(m_err));
    chk("rd_valid",   32'(bus.rd_valid),   32'(m_rd_valid));
    chk("rd_data",    32'(bus.rd_data),    32'(m_rd_data));
  endtask

  // One clock: drive inputs, check ready before the edge, update model after it
  task automatic cyc(input bit v, input bit l, input logic [7:0] d,
                     input bit rd, input bit ack, input bit rn);
    bit ready;
    bit acc;
    bit pop;
    bus.res_valid = v;
    bus.res_last  = l;
    bus.Res_reg   = d;
    bus.rd_en     = rd;
    bus.frame_ack = ack;
    reset         = rn;
    ready = (m_fifo.size() < DEPTH) && !m_done;
    @(negedge clock);
    if (m_live) chk("res_ready", 32'(bus.res_ready), 32'(ready));
    @(posedge clock);
    #1;
    cyc_n++;
    if (!rn) begin
      m_reset();
    end else begin
      acc = v && ready;
      pop = rd && (m_fifo.size() > 0);
      m_rd_valid = pop;
      if (pop) begin
        m_rd_data = m_fifo.pop_front();
        sb.push_back('{data: m_rd_data, cyc: cyc_n});
      end
      if (rd && !pop) m_err[0] = 1'b1;
      if (v && !ready) m_err[1] = 1'b1;
      if (acc) begin
        m_fifo.push_back(d);
        if (!m_collect) begin
          m_frame.delete();
          m_collect = 1;
        end
        m_frame.push_back(d);
        m_rescan();
        if (l) begin
          m_collect = 0;
          m_done    = 1;
        end
      end else if (ack && m_done) begin
        m_done = 0;
      end
    end
    if (m_live) check_state();
  endtask

  task automatic idle();
    cyc(0, 0, 8'd0, 0, 0, 1);
  endtask

  task automatic push(input logic [7:0] d, input bit l);
    cyc(1, l, d, 0, 0, 1);
  endtask

  task automatic pop1();
    cyc(0, 0, 8'd0, 1, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'd0, 0, 0, 0);
    cyc(1, 1, 8'hAA, 1, 1, 0);
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest pending pop
  always @(negedge clock) begin
    if (m_live && bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk("sb_rd_data",    32'(bus.rd_data), 32'(e.data));
        chk("sb_rd_latency", 32'(cyc_n),       32'(e.cyc));
      end
    end
  end

  initial begin
    bus.res_valid = 0;
    bus.res_last  = 0;
    bus.Res_reg   = '0;
    bus.rd_en     = 0;
    bus.frame_ack = 0;
    reset         = 0;

    do_reset();
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    idle();
    chk("post_reset_ready", 32'(bus.res_ready), 32'd1);

    // Frame 3,9,5
    push(8'd3, 0);
    push(8'd9, 0);
    push(8'd5, 1);
    chk("f1_count",      32'(bus.count),      32'd3);
    chk("f1_frame_done", 32'(bus.frame_done), 32'd1);
    chk("f1_max_val",    32'(bus.max_val),    32'd9);
    chk("f1_max_idx",    32'(bus.max_idx),    32'd1);
    chk("f1_ready",      32'(bus.res_ready),  32'd0);
    cyc(0, 0, 8'd0, 0, 1, 1);
    chk("f1_ack_clear",  32'(bus.frame_done), 32'd0);
    repeat (3) pop1();

    // Fill to full, then one excess sample
    for (int i = 0; i < 8; i++) push(8'(8'd10 + 8'(i)), 0);
    chk("fill_full",  32'(bus.full),      32'd1);
    chk("fill_ready", 32'(bus.res_ready), 32'd0);
    push(8'd99, 0);
    chk("ovf_err1",  32'(bus.err[1]), 32'd1);
    chk("ovf_count", 32'(bus.count),  32'd8);

    // Three spaced pops
    repeat (3) begin
      pop1();
      idle();
    end
    chk("pop3_count", 32'(bus.count), 32'd5);
    repeat (5) pop1();
    pop1();
    chk("underflow_err0",  32'(bus.err[0]),   32'd1);
    chk("underflow_valid", 32'(bus.rd_valid), 32'd0);

    // Tie keeps earlier index; next frame reseeds max
    do_reset();
    push(8'd7, 0);
    push(8'd7, 0);
    push(8'd2, 1);
    chk("tie_max_idx", 32'(bus.max_idx), 32'd0);
    chk("tie_max_val", 32'(bus.max_val), 32'd7);
    cyc(0, 0, 8'd0, 0, 1, 1);
    chk("tie_ack", 32'(bus.frame_done), 32'd0);
    push(8'd1, 0);
    chk("reseed_max_val", 32'(bus.max_val), 32'd1);

    // Reset during COLLECT with four entries held
    chk("pre_reset_count", 32'(bus.count), 32'd4);
    do_reset();
    chk("mid_reset_count",   32'(bus.count),   32'd0);
    chk("mid_reset_max_val", 32'(bus.max_val), 32'd0);
    chk("mid_reset_err",     32'(bus.err),     32'd0);
    push(8'd4, 0);
    push(8'd6, 1);
    chk("after_reset_max_val", 32'(bus.max_val), 32'd6);
    chk("after_reset_max_idx", 32'(bus.max_idx), 32'd1);
    cyc(0, 0, 8'd0, 0, 1, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0,
          8'($urandom),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 299) != 0);
    end

    idle();
    idle();
    @(negedge clock);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnn_res_reader.md
CNN_RES_READER -- requirements
Module: cnn_res_reader

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries; power of two, range 2..16.
REQ-002 Parameter DW, 8, result width; matches CNN Res_reg.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled on rising edge of clock.
REQ-005 Res_reg  input  DW  CNN result byte.
REQ-006 res_valid  input  1  Res_reg holds a new result this cycle.
REQ-007 res_last  input  1  qualifies res_valid; marks the final result of a frame.
REQ-008 res_ready  output  1  reader accepts a result this cycle.
REQ-009 rd_en  input  1  CPU pop request.
REQ-010 rd_data  output  DW  popped result, registered.
REQ-011 rd_valid  output  1  rd_data valid; one-cycle pulse.
REQ-012 count  output  5  FIFO occupancy, 0..DEPTH.
REQ-013 empty, full  output  1 each  count==0, count==DEPTH.
REQ-014 frame_done  output  1  a frame has ended; held until acknowledged.
REQ-015 frame_ack  input  1  CPU acknowledge of frame_done.
REQ-016 max_val  output  DW  largest result in the current or last frame.
REQ-017 max_idx  output  8  in-frame index of max_val.
REQ-018 err  output  2  sticky: bit0 underflow (rd_en while empty), bit1 protocol (res_valid while res_ready low).

Function
REQ-019 Accept = res_valid && res_ready; res_ready = !full && state!=DONE, combinational from registered state.
REQ-020 On accept, Res_reg is written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-021 Pop = rd_en && !empty; rd_data <= mem[rd_ptr], rd_valid=1 the next cycle; rd_ptr increments modulo DEPTH.
REQ-022 rd_en while empty: no pointer change, rd_valid=0 next cycle, rd_data holds, err[0] set.
REQ-023 Accept and pop in the same cycle: count unchanged; pop reads the pre-write entry; with empty FIFO only the push takes effect.
REQ-024 count updates the cycle after accept/pop; never exceeds DEPTH or underflows.
REQ-025 FSM states IDLE, COLLECT, DONE.
REQ-026 IDLE: first accept loads max_val=Res_reg, max_idx=0, sample counter=1; goes to COLLECT, or to DONE if res_last.
REQ-027 COLLECT: each accept compares Res_reg unsigned; strictly greater updates max_val and max_idx=counter; ties keep the earlier index; counter increments, saturating at 255.
REQ-028 Accept with res_last in COLLECT: comparison per REQ-027 still applies, then DONE with frame_done=1 the next cycle.
REQ-029 DONE: res_ready=0; frame_ack returns to IDLE and clears frame_done the next cycle; max_val/max_idx hold until the next frame's first accept.
REQ-030 frame_ack outside DONE: ignored.
REQ-031 res_valid while res_ready=0 sets err[1]; the sample is dropped and has no effect on FIFO or max tracking.
REQ-032 err bits clear only on reset.

Reset
REQ-033 reset low at a rising edge: state=IDLE, pointers=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, frame_done=0, max_val=0, max_idx=0, err=0, counter=0.
REQ-034 Reset mid-frame or mid-read discards all FIFO contents and frame progress; res_ready=1 the first cycle after reset is released.
REQ-035 Inputs are ignored on cycles where reset is low.

Verification
REQ-036 Reset, then push 3,9,5 with last on 5 -> count=3, frame_done=1, max_val=9, max_idx=1, res_ready=0.
REQ-037 Push 8 values without last -> full=1, res_ready=0; a 9th res_valid -> err[1]=1, count stays 8.
REQ-038 Full FIFO, three rd_en pulses -> rd_data returns the first 3 values in order, rd_valid pulses one cycle after each pulse, count=5.
REQ-039 rd_en on empty FIFO -> rd_valid stays 0, err[0]=1.
REQ-040 Frame 7,7,2 with last on 2 -> max_idx=0; frame_ack -> frame_done=0 next cycle, state IDLE; next frame's first sample 1 -> max_val=1.
REQ-041 Assert reset in COLLECT with count=4 -> all outputs reach REQ-033 values; the next frame accepts normally.
